// File: rtl/datapath_ctrl.sv
// Control FSM for ARM data-processing instructions: accepts an instruction word,
// checks its condition, then sequences the operand-read and execute steps.
module datapath_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic [31:0] status_in,
  output logic [3:0]  A_addr,
  output logic [3:0]  B_addr,
  output logic [3:0]  shift_addr,
  output logic [3:0]  w_addr1,
  output logic        w_en1,
  output logic [3:0]  w_addr2,
  output logic        w_en2,
  output logic        forward_w_data,
  output logic [1:0]  sel_A_in,
  output logic [1:0]  sel_B_in,
  output logic [1:0]  sel_shift_in,
  output logic        en_A,
  output logic        en_B,
  output logic        en_S,
  output logic        en_status,
  output logic        sel_shift,
  output logic [31:0] shift_imme,
  output logic [1:0]  shift_op,
  output logic        sel_A,
  output logic        sel_B,
  output logic        sel_post_shift,
  output logic [31:0] imme_data,
  output logic [2:0]  ALU_op,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] ir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && instr_valid)
        ir <= instr;
    end
  end

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ok;

  assign flag_n = status_in[31];
  assign flag_z = status_in[30];
  assign flag_c = status_in[29];
  assign flag_v = status_in[28];

  always_comb begin
    cond_ok = 1'b0;
    case (ir[31:28])
      4'b0000: cond_ok = flag_z;
      4'b0001: cond_ok = !flag_z;
      4'b0010: cond_ok = flag_c;
      4'b0011: cond_ok = !flag_c;
      4'b0100: cond_ok = flag_n;
      4'b0101: cond_ok = !flag_n;
      4'b0110: cond_ok = flag_v;
      4'b0111: cond_ok = !flag_v;
      4'b1000: cond_ok = flag_c && !flag_z;
      4'b1001: cond_ok = !flag_c || flag_z;
      4'b1010: cond_ok = flag_n == flag_v;
      4'b1011: cond_ok = flag_n != flag_v;
      4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ok = flag_z || (flag_n != flag_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  logic [3:0] opc;
  logic       op_and, op_eor, op_sub, op_add;
  logic       op_cmp, op_orr, op_mov;
  logic       op_ok;
  logic       run;

  assign opc    = ir[24:21];
  assign op_and = opc == 4'b0000;
  assign op_eor = opc == 4'b0001;
  assign op_sub = opc == 4'b0010;
  assign op_add = opc == 4'b0100;
  assign op_cmp = opc == 4'b1010;
  assign op_orr = opc == 4'b1100;
  assign op_mov = opc == 4'b1101;
  assign op_ok  = op_and | op_eor | op_sub | op_add
                | op_cmp | op_orr | op_mov;
  assign run    = cond_ok && (ir[27:26] == 2'b00) && op_ok;

  // Rotating a doubled copy right gives ROR in the low word.
  logic [4:0]  rot;
  logic [63:0] imm_dbl;
  logic [63:0] imm_shr;

  assign rot     = {ir[11:8], 1'b0};
  assign imm_dbl = {24'b0, ir[7:0], 24'b0, ir[7:0]};
  assign imm_shr = imm_dbl >> rot;

  logic [2:0] alu_dec;

  always_comb begin
    alu_dec = 3'b000;
    unique case (1'b1)
      op_add, op_mov: alu_dec = 3'b000;
      op_sub, op_cmp: alu_dec = 3'b001;
      op_and:         alu_dec = 3'b010;
      op_orr:         alu_dec = 3'b011;
      op_eor:         alu_dec = 3'b100;
      default:        alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    state_nx       = state;
    instr_ready    = 1'b0;
    A_addr         = '0;
    B_addr         = '0;
    shift_addr     = '0;
    w_addr1        = '0;
    w_en1          = 1'b0;
    w_addr2        = '0;
    w_en2          = 1'b0;
    forward_w_data = 1'b0;
    sel_A_in       = '0;
    sel_B_in       = '0;
    sel_shift_in   = '0;
    en_A           = 1'b0;
    en_B           = 1'b0;
    en_S           = 1'b0;
    en_status      = 1'b0;
    sel_shift      = 1'b0;
    shift_imme     = '0;
    shift_op       = '0;
    sel_A          = 1'b0;
    sel_B          = 1'b0;
    sel_post_shift = 1'b0;
    imme_data      = '0;
    ALU_op         = '0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_nx = DECODE;
      end
      DECODE: begin
        if (run) begin
          en_A       = 1'b1;
          en_B       = 1'b1;
          en_S       = 1'b1;
          A_addr     = ir[19:16];
          B_addr     = ir[3:0];
          shift_addr = ir[11:8];
          sel_shift  = ir[4];
          shift_imme = {27'b0, ir[11:7]};
          state_nx   = EXEC;
        end else begin
          state_nx   = DONE;
        end
      end
      EXEC: begin
        shift_op  = ir[25] ? 2'b11 : ir[6:5];
        sel_B     = ir[25];
        imme_data = imm_shr[31:0];
        sel_A     = op_mov;
        ALU_op    = alu_dec;
        w_addr1   = ir[15:12];
        w_en1     = !op_cmp;
        en_status = ir[20] | op_cmp;
        state_nx  = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
